// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the fetch / load-store arbiter.
package mem_arbiter_pkg;
   typedef logic [15:0] memory_address_t;
   typedef logic [31:0] memory_data_t;
   typedef enum logic {MEM_MODE_READ = 1'b0, MEM_MODE_WRITE = 1'b1} memory_mode_t;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (F) and load/store (D) onto one memory port, one transaction at a time.
// Latency >= 2 cycles ready->rsp; requesters hold valid until their ready pulse, memory stalls via i_mem_ready.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int RR_ENABLE  = 1,
   parameter int RD_TIMEOUT = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_f_valid,
   output logic            o_f_ready,
   input  memory_address_t i_f_addr,
   output logic            o_f_rsp_valid,
   output memory_data_t    o_f_rsp_data,
   output logic            o_f_rsp_err,
   input  logic            i_d_valid,
   output logic            o_d_ready,
   input  memory_address_t i_d_addr,
   input  memory_mode_t    i_d_mode,
   input  memory_data_t    i_d_wr_data,
   output logic            o_d_rsp_valid,
   output memory_data_t    o_d_rsp_data,
   output logic            o_d_rsp_err,
   output logic            o_mem_valid,
   input  logic            i_mem_ready,
   output memory_address_t o_mem_addr,
   output memory_mode_t    o_mem_mode,
   output memory_data_t    o_mem_wr_data,
   input  memory_data_t    i_mem_rd_data,
   input  logic            i_mem_rd_valid
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_RESP_WAIT = 2'd2;
   localparam logic       PORT_F       = 1'b0;
   localparam logic       PORT_D       = 1'b1;
   localparam int         TW           = $clog2(RD_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

   logic [1:0]      state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_grant_q, last_grant_d;
   memory_address_t addr_q, addr_d;
   memory_mode_t    mode_q, mode_d;
   memory_data_t    wdata_q, wdata_d;
   memory_data_t    rsp_data_q, rsp_data_d;
   logic            rsp_vld_q, rsp_vld_d;
   logic            rsp_err_q, rsp_err_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            grant_f, grant_d, idle;
   logic            f_rsp, d_rsp;

   always_comb begin
      idle = (state_q == ST_IDLE);
      // On a tie, round-robin hands the grant to whoever did not go last.
      if (i_f_valid && i_d_valid) begin
         grant_d = (RR_ENABLE != 0) ? (last_grant_q == PORT_F) : 1'b1;
      end else begin
         grant_d = i_d_valid;
      end
      grant_f = i_f_valid && !grant_d;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      mode_d       = mode_q;
      wdata_d      = wdata_q;
      timer_d      = timer_q;
      rsp_vld_d    = 1'b0;
      rsp_err_d    = 1'b0;
      rsp_data_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_f || grant_d) begin
               owner_d = grant_d;
               state_d = ST_ISSUE;
               if (grant_d) begin
                  addr_d  = i_d_addr;
                  mode_d  = i_d_mode;
                  wdata_d = i_d_wr_data;
               end else begin
                  addr_d  = i_f_addr;
                  mode_d  = MEM_MODE_READ;
                  wdata_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (i_mem_ready) begin
               last_grant_d = owner_q;
               timer_d      = '0;
               if (mode_q == MEM_MODE_WRITE) begin
                  rsp_vld_d = 1'b1;
                  state_d   = ST_IDLE;
               end else if (i_mem_rd_valid) begin
                  rsp_vld_d  = 1'b1;
                  rsp_data_d = i_mem_rd_data;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_RESP_WAIT;
               end
            end
         end
         ST_RESP_WAIT: begin
            // Data arriving on the last wait cycle still beats the timeout.
            if (i_mem_rd_valid) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = i_mem_rd_data;
               state_d    = ST_IDLE;
            end else if (timer_q == TIMER_LAST) begin
               rsp_vld_d = 1'b1;
               rsp_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= PORT_F;
         last_grant_q <= PORT_D;
         addr_q       <= '0;
         mode_q       <= MEM_MODE_READ;
         wdata_q      <= '0;
         timer_q      <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         mode_q       <= mode_d;
         wdata_q      <= wdata_d;
         timer_q      <= timer_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   // owner_q still names the finished request during the response cycle.
   assign f_rsp         = rsp_vld_q && (owner_q == PORT_F);
   assign d_rsp         = rsp_vld_q && (owner_q == PORT_D);
   assign o_f_ready     = i_rst && idle && grant_f;
   assign o_d_ready     = i_rst && idle && grant_d;
   assign o_f_rsp_valid = f_rsp;
   assign o_f_rsp_data  = f_rsp ? rsp_data_q : '0;
   assign o_f_rsp_err   = f_rsp && rsp_err_q;
   assign o_d_rsp_valid = d_rsp;
   assign o_d_rsp_data  = d_rsp ? rsp_data_q : '0;
   assign o_d_rsp_err   = d_rsp && rsp_err_q;
   assign o_mem_valid   = (state_q == ST_ISSUE);
   assign o_mem_addr    = addr_q;
   assign o_mem_mode    = mode_q;
   assign o_mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance sharing the same stimulus.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            f_valid, d_valid, mem_ready, rd_valid;
   memory_address_t f_addr, d_addr;
   memory_mode_t    d_mode;
   memory_data_t    d_wdata, rd_data;

   logic            f_ready, f_rsp_valid, f_rsp_err, d_ready, d_rsp_valid, d_rsp_err, mem_valid;
   memory_data_t    f_rsp_data, d_rsp_data, mem_wr_data;
   memory_address_t mem_addr;
   memory_mode_t    mem_mode;

   logic            fp_f_ready, fp_f_rsp_valid, fp_f_rsp_err, fp_d_ready, fp_d_rsp_valid, fp_d_rsp_err, fp_mem_valid;
   memory_data_t    fp_f_rsp_data, fp_d_rsp_data, fp_mem_wr_data;
   memory_address_t fp_mem_addr;
   memory_mode_t    fp_mem_mode;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.RR_ENABLE(1), .RD_TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_f_valid(f_valid), .o_f_ready(f_ready), .i_f_addr(f_addr),
      .o_f_rsp_valid(f_rsp_valid), .o_f_rsp_data(f_rsp_data), .o_f_rsp_err(f_rsp_err),
      .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_addr(d_addr), .i_d_mode(d_mode),
      .i_d_wr_data(d_wdata),
      .o_d_rsp_valid(d_rsp_valid), .o_d_rsp_data(d_rsp_data), .o_d_rsp_err(d_rsp_err),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
      .o_mem_mode(mem_mode), .o_mem_wr_data(mem_wr_data),
      .i_mem_rd_data(rd_data), .i_mem_rd_valid(rd_valid)
   );

   mem_arbiter #(.RR_ENABLE(0), .RD_TIMEOUT(16)) dut_fp (
      .i_clk(clk), .i_rst(rst_n),
      .i_f_valid(f_valid), .o_f_ready(fp_f_ready), .i_f_addr(f_addr),
      .o_f_rsp_valid(fp_f_rsp_valid), .o_f_rsp_data(fp_f_rsp_data), .o_f_rsp_err(fp_f_rsp_err),
      .i_d_valid(d_valid), .o_d_ready(fp_d_ready), .i_d_addr(d_addr), .i_d_mode(d_mode),
      .i_d_wr_data(d_wdata),
      .o_d_rsp_valid(fp_d_rsp_valid), .o_d_rsp_data(fp_d_rsp_data), .o_d_rsp_err(fp_d_rsp_err),
      .o_mem_valid(fp_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(fp_mem_addr),
      .o_mem_mode(fp_mem_mode), .o_mem_wr_data(fp_mem_wr_data),
      .i_mem_rd_data(rd_data), .i_mem_rd_valid(rd_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; f_valid = 0; d_valid = 0; mem_ready = 0; rd_valid = 0;
      f_addr = '0; d_addr = '0; d_mode = MEM_MODE_READ; d_wdata = '0; rd_data = '0;
      #3;
      n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_valid); end
      n_cmp++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      n_cmp++; if (mem_mode !== MEM_MODE_READ) begin n_fail++; $display("FAIL rst_mem_mode got=%0d exp=0", mem_mode); end
      n_cmp++; if (mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wr_data got=%h exp=0", mem_wr_data); end
      n_cmp++; if ({f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err} !== 4'b0) begin n_fail++; $display("FAIL rst_rsp got=%b exp=0000", {f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err}); end
      n_cmp++; if ({f_rsp_data, d_rsp_data} !== 64'h0) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=0", {f_rsp_data, d_rsp_data}); end
      f_valid = 1; d_valid = 1;
      #1;
      n_cmp++; if ({f_ready, d_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", {f_ready, d_ready}); end
      f_valid = 0; d_valid = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_f_read();
      f_valid = 1; f_addr = 16'h0010; #1;
      n_cmp++; if ({f_ready, d_ready} !== 2'b10) begin n_fail++; $display("FAIL t1_ready got=%b exp=10", {f_ready, d_ready}); end
      step(); f_valid = 0; f_addr = '0; mem_ready = 1; #1;
      n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0010 || mem_mode !== MEM_MODE_READ) begin n_fail++; $display("FAIL t1_issue got=%b/%h/%0d exp=1/0010/0", mem_valid, mem_addr, mem_mode); end
      step(); mem_ready = 0; #1;
      n_cmp++; if (mem_valid !== 1'b0 || f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_wait0 got=%b%b exp=00", mem_valid, f_rsp_valid); end
      step(); #1;
      n_cmp++; if (f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_wait1 got=%b exp=0", f_rsp_valid); end
      step(); rd_valid = 1; rd_data = 32'h0000_00A5; #1;
      n_cmp++; if (f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_wait2 got=%b exp=0", f_rsp_valid); end
      step(); rd_valid = 0; rd_data = '0; #1;
      n_cmp++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hA5 || f_rsp_err !== 1'b0 || d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp got=%b/%h/%b/%b exp=1/a5/0/0", f_rsp_valid, f_rsp_data, f_rsp_err, d_rsp_valid); end
      step(); #1;
      n_cmp++; if (f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_pulse got=%b exp=0", f_rsp_valid); end
   endtask

   task automatic test_d_write_stall();
      d_valid = 1; d_addr = 16'h0020; d_mode = MEM_MODE_WRITE; d_wdata = 32'h3C; #1;
      n_cmp++; if ({f_ready, d_ready} !== 2'b01) begin n_fail++; $display("FAIL t2_ready got=%b exp=01", {f_ready, d_ready}); end
      for (int i = 0; i < 4; i++) begin
         step(); d_valid = 0; d_addr = 16'hFFFF; d_mode = MEM_MODE_READ; d_wdata = 32'hFFFF_FFFF; #1;
         n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0020 || mem_mode !== MEM_MODE_WRITE || mem_wr_data !== 32'h3C || d_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL t2_stall%0d got=%b/%h/%0d/%h/%b exp=1/0020/1/3c/0", i, mem_valid, mem_addr, mem_mode, mem_wr_data, d_rsp_valid);
         end
      end
      step(); mem_ready = 1; #1;
      n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL t2_hs got=%b exp=1", mem_valid); end
      step(); mem_ready = 0; #1;
      n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0 || d_rsp_err !== 1'b0 || f_rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin
         n_fail++; $display("FAIL t2_rsp got=%b/%h/%b/%b/%b exp=1/0/0/0/0", d_rsp_valid, d_rsp_data, d_rsp_err, f_rsp_valid, mem_valid);
      end
      step();
   endtask

   task automatic test_arbitration();
      logic [7:0] e_f_rdy  = 8'b0001_0001;
      logic [7:0] e_d_rdy  = 8'b0100_0100;
      logic [7:0] e_f_rsp  = 8'b0100_0100;
      logic [7:0] e_d_rsp  = 8'b0001_0000;
      logic [7:0] e_fp_rsp = 8'b0101_0100;
      logic [7:0] e_mv     = 8'b1010_1010;
      logic [7:0] e_hi     = 8'b1000_1000;
      memory_address_t e_addr;
      f_valid = 1; f_addr = 16'h0100; d_valid = 1; d_addr = 16'h0200; d_mode = MEM_MODE_READ;
      mem_ready = 1; rd_valid = 1; rd_data = 32'h77;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_cmp++; if ({f_ready, d_ready} !== {e_f_rdy[i], e_d_rdy[i]}) begin n_fail++; $display("FAIL t3_rr_grant%0d got=%b exp=%b", i, {f_ready, d_ready}, {e_f_rdy[i], e_d_rdy[i]}); end
         n_cmp++; if ({fp_f_ready, fp_d_ready} !== {1'b0, ~e_mv[i]}) begin n_fail++; $display("FAIL t3_fp_grant%0d got=%b exp=%b", i, {fp_f_ready, fp_d_ready}, {1'b0, ~e_mv[i]}); end
         n_cmp++; if ({f_rsp_valid, d_rsp_valid, fp_f_rsp_valid, fp_d_rsp_valid} !== {e_f_rsp[i], e_d_rsp[i], 1'b0, e_fp_rsp[i]}) begin
            n_fail++; $display("FAIL t3_rsp%0d got=%b exp=%b", i, {f_rsp_valid, d_rsp_valid, fp_f_rsp_valid, fp_d_rsp_valid}, {e_f_rsp[i], e_d_rsp[i], 1'b0, e_fp_rsp[i]});
         end
         if (e_mv[i]) begin
            e_addr = e_hi[i] ? 16'h0200 : 16'h0100;
            n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== e_addr || fp_mem_addr !== 16'h0200) begin n_fail++; $display("FAIL t3_addr%0d got=%b/%h/%h exp=1/%h/0200", i, mem_valid, mem_addr, fp_mem_addr, e_addr); end
         end
         step();
      end
      f_valid = 0; d_valid = 0; mem_ready = 0; rd_valid = 0; rd_data = '0; #1;
      n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h77 || fp_d_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t3_last_rsp got=%b/%h/%b exp=1/77/1", d_rsp_valid, d_rsp_data, fp_d_rsp_valid); end
      step();
   endtask

   task automatic test_timeout();
      d_valid = 1; d_addr = 16'h0044; d_mode = MEM_MODE_READ; #1;
      n_cmp++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready got=%b exp=1", d_ready); end
      step(); d_valid = 0; mem_ready = 1; #1;
      n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL t4_issue got=%b exp=1", mem_valid); end
      for (int i = 0; i < 16; i++) begin
         step(); mem_ready = 0; #1;
         n_cmp++; if (d_rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL t4_wait%0d got=%b%b exp=00", i, d_rsp_valid, mem_valid); end
      end
      step(); rd_valid = 1; rd_data = 32'hDEAD; #1;
      n_cmp++; if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_data !== 32'h0) begin n_fail++; $display("FAIL t4_timeout got=%b/%b/%h exp=1/1/0", d_rsp_valid, d_rsp_err, d_rsp_data); end
      step(); rd_valid = 0; rd_data = '0; #1;
      n_cmp++; if ({d_rsp_valid, f_rsp_valid, d_rsp_err, mem_valid} !== 4'b0) begin n_fail++; $display("FAIL t4_late got=%b exp=0000", {d_rsp_valid, f_rsp_valid, d_rsp_err, mem_valid}); end
      step();
   endtask

   task automatic test_back_to_back();
      f_valid = 1; f_addr = 16'h0055; #1;
      n_cmp++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready got=%b exp=1", f_ready); end
      step(); f_valid = 0; mem_ready = 1; rd_valid = 1; rd_data = 32'h1234_5678; #1;
      n_cmp++; if (mem_valid !== 1'b1 || mem_addr !== 16'h0055) begin n_fail++; $display("FAIL t5_issue got=%b/%h exp=1/0055", mem_valid, mem_addr); end
      step(); mem_ready = 0; rd_valid = 0; rd_data = '0; #1;
      n_cmp++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h1234_5678 || f_rsp_err !== 1'b0 || mem_valid !== 1'b0) begin
         n_fail++; $display("FAIL t5_rsp got=%b/%h/%b/%b exp=1/12345678/0/0", f_rsp_valid, f_rsp_data, f_rsp_err, mem_valid);
      end
      step(); #1;
      n_cmp++; if (f_rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL t5_idle got=%b%b exp=00", f_rsp_valid, mem_valid); end
   endtask

   task automatic test_reset_mid();
      d_valid = 1; d_addr = 16'h0066; d_mode = MEM_MODE_READ; #1;
      n_cmp++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready got=%b exp=1", d_ready); end
      step(); d_valid = 0; mem_ready = 1;
      step(); mem_ready = 0; #1;
      n_cmp++; if (mem_valid !== 1'b0 || mem_addr !== 16'h0066) begin n_fail++; $display("FAIL t6_wait got=%b/%h exp=0/0066", mem_valid, mem_addr); end
      #2; rst_n = 0; f_valid = 1; d_valid = 1; #1;
      n_cmp++; if (mem_addr !== 16'h0 || fp_mem_addr !== 16'h0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async got=%h/%h/%b exp=0/0/0", mem_addr, fp_mem_addr, mem_valid); end
      n_cmp++; if ({f_ready, d_ready, f_rsp_valid, d_rsp_valid, d_rsp_err} !== 5'b0) begin n_fail++; $display("FAIL t6_async_ctl got=%b exp=00000", {f_ready, d_ready, f_rsp_valid, d_rsp_valid, d_rsp_err}); end
      step(); step();
      f_valid = 0; d_valid = 0; rst_n = 1; rd_valid = 1; rd_data = 32'hBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if ({f_rsp_valid, d_rsp_valid, fp_d_rsp_valid, mem_valid} !== 4'b0) begin n_fail++; $display("FAIL t6_stale%0d got=%b exp=0000", i, {f_rsp_valid, d_rsp_valid, fp_d_rsp_valid, mem_valid}); end
         step(); rd_valid = 0; rd_data = '0;
      end
      f_valid = 1; f_addr = 16'h0011; d_valid = 1; d_addr = 16'h0022; #1;
      n_cmp++; if ({f_ready, d_ready} !== 2'b10) begin n_fail++; $display("FAIL t6_first_tie got=%b exp=10", {f_ready, d_ready}); end
      n_cmp++; if ({fp_f_ready, fp_d_ready} !== 2'b01) begin n_fail++; $display("FAIL t6_fp_tie got=%b exp=01", {fp_f_ready, fp_d_ready}); end
      step(); f_valid = 0; d_valid = 0; #1;
      n_cmp++; if (mem_addr !== 16'h0011 || fp_mem_addr !== 16'h0022) begin n_fail++; $display("FAIL t6_grant_addr got=%h/%h exp=0011/0022", mem_addr, fp_mem_addr); end
   endtask

   initial begin
      test_reset();
      test_f_read();
      test_d_write_stall();
      test_arbitration();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
